mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the CPU's instruction-fetch port and its load/store data port.
- Arbitrates between the two requesters round-robin and allows one outstanding transaction at a time.
- Sequences each transaction through issue and response phases, then routes read data back to the winning requester.
- Sits between the cpu core and the memory model, and is instantiated inside cpu.

Parameters:
- ADDRESS_WIDTH, 32, width of all address buses
- DATA_WIDTH, 32, width of all data buses; must be a multiple of 8
- TIMEOUT_CYCLES, 16, read-response timeout; used only with MEM_ARB_TIMEOUT_EN

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDRESS_WIDTH  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_WIDTH  fetched instruction
- d_req  in  1  data request; payload held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDRESS_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_be  in  DATA_WIDTH/8  store byte enables
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse: d_rdata valid (loads only)
- d_rdata  out  DATA_WIDTH  load data
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDRESS_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_be  out  DATA_WIDTH/8  memory byte enables
- mem_ready  in  1  memory accepts the request on this edge
- mem_rvalid  in  1  memory read data valid
- mem_rdata  in  DATA_WIDTH  memory read data
- bus_err  out  1  present only with MEM_ARB_TIMEOUT_EN

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including the rdata buses and the latched payload.
  - last_owner = FETCH, so data wins the first tie.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Only if_req is high: fetch wins.
  - Only d_req is high: data wins.
  - Both high: the requester that is not last_owner wins.
  - On the edge with a winner: latch the payload into registers, go to ISSUE, set owner and last_owner, and pulse the winner's gnt high for exactly the following cycle.
  - Fetch payload is latched as we=0, be=all-ones, wdata=0.
- ISSUE:
  - mem_req=1 and the mem_* buses are driven from registers, held stable until an edge where mem_ready=1.
  - On acceptance, a load or fetch goes to WAIT; a store goes to IDLE. Stores produce no rvalid.
- WAIT:
  - mem_req=0.
  - On the edge where mem_rvalid=1, register mem_rdata into the owner's rdata, pulse the owner's rvalid for the next cycle, and go to IDLE.
  - The non-owner's rdata and rvalid are unchanged.
- mem_rvalid is ignored outside WAIT.
- rdata registers hold their last value between transactions.
- Minimum read latency, with mem_ready and mem_rvalid both immediate:
  - req seen in cycle 0, gnt in cycle 1, mem_req in cycle 1, WAIT in cycle 2, rvalid in cycle 3.
  - A store occupies 2 cycles from IDLE back to IDLE.
- A request arriving while not in IDLE waits. It is arbitrated on the first IDLE edge, so no request is lost provided it is held.
- A requester dropping req before gnt is legal; it is simply not served.
- Reset asserted mid-transaction:
  - Returns to IDLE with no gnt or rvalid.
  - A memory response that arrives later is ignored.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without mem_rvalid, the owner's rvalid pulses with rdata=0 and bus_err pulses in the same cycle, then the FSM returns to IDLE.
  - The counter resets to 0.
- Without the macro:
  - WAIT waits indefinitely.
  - The bus_err port and the counter do not exist.

Test Plan:
- Reset then fetch only: if_addr=0x0000_0004, mem_ready=1, memory returns 0x0000_0093 one cycle after acceptance -> if_gnt in cycle 1, mem_addr=0x4 with mem_we=0 and mem_be=4'hF, if_rvalid in cycle 3 with if_rdata=0x0000_0093, d_rvalid never asserted.
- Store: d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_be=4'b0011, mem_ready low for 2 cycles -> mem_req held 3 cycles with stable payload, d_gnt exactly once, no d_rvalid, IDLE after acceptance.
- Both requesting continuously for 4 transactions after reset -> grant order D, I, D, I, each rdata routed only to its owner.
- rst pulled low during WAIT, mem_rvalid arrives after rst returns high -> no rvalid pulse, all outputs 0, next request served normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, a load never answered -> after 16 WAIT cycles d_rvalid=1, d_rdata=0, bus_err=1 for one cycle, then a subsequent fetch completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// port and the load/store data port. Round-robin arbitration, one
// outstanding transaction, response routed back to the winner.
//
// Optional build macro: MEM_ARB_TIMEOUT_EN adds a read-response timeout
// (TIMEOUT_CYCLES WAIT cycles) and the bus_err output.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   if_req/if_addr    fetch request, held until if_gnt
//   if_gnt            one-cycle grant pulse for fetch
//   if_rvalid/if_rdata fetch response
//   d_req/d_we/d_addr/d_wdata/d_be  data request payload, held until d_gnt
//   d_gnt             one-cycle grant pulse for data
//   d_rvalid/d_rdata  load response
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  memory request (registered)
//   mem_ready         memory accepts the request on this edge
//   mem_rvalid/mem_rdata  memory read response
//   bus_err           read timeout pulse (MEM_ARB_TIMEOUT_EN only)
module mem_arbiter #(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [ADDRESS_WIDTH-1:0]  if_addr,
  output logic                      if_gnt,
  output logic                      if_rvalid,
  output logic [DATA_WIDTH-1:0]     if_rdata,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [ADDRESS_WIDTH-1:0]  d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  input  logic [DATA_WIDTH/8-1:0]   d_be,
  output logic                      d_gnt,
  output logic                      d_rvalid,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDRESS_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_be,
  input  logic                      mem_ready,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic                      bus_err
`endif
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  state_t                     state_q, state_d;
  owner_t                     owner_q, owner_d;
  owner_t                     last_q, last_d;
  logic                       pick_data;
  logic                       mem_req_d, mem_we_d;
  logic [ADDRESS_WIDTH-1:0]   mem_addr_d;
  logic [DATA_WIDTH-1:0]      mem_wdata_d;
  logic [BE_WIDTH-1:0]        mem_be_d;
  logic                       if_gnt_d, d_gnt_d;
  logic                       if_rvalid_d, d_rvalid_d;
  logic [DATA_WIDTH-1:0]      if_rdata_d, d_rdata_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
  logic                       bus_err_d;
`endif

  // Next-state, payload latch, grant and response routing
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    pick_data   = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_be_d    = mem_be;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    bus_err_d   = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // Data wins alone, or on a tie when fetch owned the last slot
        pick_data = d_req && (!if_req || (last_q == OWN_FETCH));
        if (pick_data) begin
          state_d     = ST_ISSUE;
          owner_d     = OWN_DATA;
          last_d      = OWN_DATA;
          d_gnt_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
        end else if (if_req) begin
          state_d     = ST_ISSUE;
          owner_d     = OWN_FETCH;
          last_d      = OWN_FETCH;
          if_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
        end
      end

      ST_ISSUE: begin
        mem_req_d = 1'b1;
        if (mem_ready) begin
          mem_req_d = 1'b0;
          // Stores complete on acceptance; reads wait for data
          state_d   = mem_we ? ST_IDLE : ST_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end

      ST_WAIT: begin
        if (mem_rvalid) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_DATA) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d = '0;
        end else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
          // Last permitted WAIT cycle passed without data: fail the read
          state_d   = ST_IDLE;
          cnt_d     = '0;
          bus_err_d = 1'b1;
          if (owner_q == OWN_DATA) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = '0;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_FETCH;
      last_q    <= OWN_FETCH;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      bus_err   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_be    <= mem_be_d;
      if_gnt    <= if_gnt_d;
      d_gnt     <= d_gnt_d;
      if_rvalid <= if_rvalid_d;
      d_rvalid  <= d_rvalid_d;
      if_rdata  <= if_rdata_d;
      d_rdata   <= d_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      bus_err   <= bus_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model,
// per-cycle output comparison, and directed scenarios with literal checks.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [BW-1:0] d_be = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
`ifdef MEM_ARB_TIMEOUT_EN
  logic          bus_err;
`endif

  mem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_TIMEOUT_EN
    , .bus_err(bus_err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] resp_data(input logic [31:0] a);
    if (a == 32'h4) return 32'h0000_0093;
    return {~a[15:0], a[15:0]};
  endfunction

  // ---------------- requesters ----------------
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [BW-1:0] be;
    int            life;   // cycles to hold before giving up, 0 = hold forever
  } req_t;

  req_t iq[$];
  req_t dq[$];
  int   i_age = 0, d_age = 0;
  int   if_req_cyc = 0, d_req_cyc = 0;

  always @(negedge clk) begin : drv_if
    if (if_req) begin
      if (if_gnt) begin
        iq.delete(0);
        i_age = 0;
      end else begin
        i_age++;
        if (iq[0].life != 0 && i_age >= iq[0].life) begin
          iq.delete(0);
          i_age = 0;
        end
      end
    end
    if (iq.size() != 0) begin
      if (i_age == 0) if_req_cyc = cyc;
      if_req  = 1'b1;
      if_addr = iq[0].addr;
    end else begin
      if_req  = 1'b0;
      if_addr = AW'($urandom);
    end
  end

  always @(negedge clk) begin : drv_d
    if (d_req) begin
      if (d_gnt) begin
        dq.delete(0);
        d_age = 0;
      end else begin
        d_age++;
        if (dq[0].life != 0 && d_age >= dq[0].life) begin
          dq.delete(0);
          d_age = 0;
        end
      end
    end
    if (dq.size() != 0) begin
      if (d_age == 0) d_req_cyc = cyc;
      d_req   = 1'b1;
      d_we    = dq[0].we;
      d_addr  = dq[0].addr;
      d_wdata = dq[0].wdata;
      d_be    = dq[0].be;
    end else begin
      d_req   = 1'b0;
      d_we    = 1'($urandom);
      d_addr  = AW'($urandom);
      d_wdata = DW'($urandom);
      d_be    = BW'($urandom);
    end
  end

  // ---------------- memory model ----------------
  int            cfg_stall = 0, cfg_lat = 1, stall_left = 0;
  bit            cfg_noresp = 1'b0;
  bit            resp_pend = 1'b0;
  int            resp_wait = 0;
  logic [DW-1:0] resp_val = '0;

  always @(negedge clk) begin : memory
    mem_rvalid = 1'b0;
    mem_rdata  = DW'($urandom);
    if (resp_pend) begin
      if (resp_wait == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = resp_val;
        resp_pend  = 1'b0;
      end else begin
        resp_wait--;
      end
    end
    if (mem_req) begin
      if (stall_left > 0) begin
        mem_ready = 1'b0;
        stall_left--;
      end else begin
        mem_ready  = 1'b1;
        stall_left = cfg_stall;
        if (!mem_we && !cfg_noresp) begin
          resp_pend = 1'b1;
          resp_wait = cfg_lat - 1;
          resp_val  = resp_data(mem_addr);
        end
      end
    end else begin
      mem_ready = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  // One transaction record: who owns it, its payload, and whether the
  // memory has taken it yet. Expected outputs are for the cycle after the edge.
  bit            m_valid = 1'b0, m_acc = 1'b0, m_data = 1'b0, m_last_data = 1'b0, m_we = 1'b0;
  int            m_wait = 0;
  logic          e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_err, e_mem_req, e_mem_we;
  logic [DW-1:0] e_if_rdata, e_d_rdata, e_mem_wdata;
  logic [AW-1:0] e_mem_addr;
  logic [BW-1:0] e_mem_be;

  task automatic deliver(input logic [DW-1:0] v);
    if (m_data) begin e_d_rv = 1'b1; e_d_rdata = v; end
    else        begin e_if_rv = 1'b1; e_if_rdata = v; end
    m_valid = 1'b0;
    m_acc   = 1'b0;
  endtask

  always @(posedge clk or negedge rst) begin : model
    if (!rst) begin
      m_valid = 1'b0; m_acc = 1'b0; m_data = 1'b0; m_last_data = 1'b0; m_we = 1'b0; m_wait = 0;
      e_if_gnt = 1'b0; e_d_gnt = 1'b0; e_if_rv = 1'b0; e_d_rv = 1'b0; e_err = 1'b0;
      e_mem_req = 1'b0; e_mem_we = 1'b0; e_if_rdata = '0; e_d_rdata = '0;
      e_mem_wdata = '0; e_mem_addr = '0; e_mem_be = '0;
    end else begin
      e_if_gnt = 1'b0; e_d_gnt = 1'b0; e_if_rv = 1'b0; e_d_rv = 1'b0; e_err = 1'b0;
      if (!m_valid) begin
        if (d_req && (!if_req || !m_last_data)) begin
          m_valid = 1'b1; m_acc = 1'b0; m_data = 1'b1; m_last_data = 1'b1; m_we = d_we;
          e_d_gnt = 1'b1;
          e_mem_we = d_we; e_mem_addr = d_addr; e_mem_wdata = d_wdata; e_mem_be = d_be;
        end else if (if_req) begin
          m_valid = 1'b1; m_acc = 1'b0; m_data = 1'b0; m_last_data = 1'b0; m_we = 1'b0;
          e_if_gnt = 1'b1;
          e_mem_we = 1'b0; e_mem_addr = if_addr; e_mem_wdata = '0; e_mem_be = '1;
        end
      end else if (!m_acc) begin
        if (mem_ready) begin
          if (m_we) m_valid = 1'b0;
          else begin m_acc = 1'b1; m_wait = 0; end
        end
      end else begin
        if (mem_rvalid) deliver(mem_rdata);
        else begin
          m_wait++;
`ifdef MEM_ARB_TIMEOUT_EN
          if (m_wait == TO) begin
            deliver('0);
            e_err = 1'b1;
          end
`endif
        end
      end
      e_mem_req = m_valid && !m_acc;
    end
  end

  // ---------------- per-cycle comparison and event log ----------------
  int            if_gnt_cnt = 0, d_gnt_cnt = 0, if_rv_cnt = 0, d_rv_cnt = 0, err_cnt = 0;
  int            if_gnt_cyc = 0, d_gnt_cyc = 0, if_rv_cyc = 0, d_rv_cyc = 0, err_cyc = 0;
  int            mem_req_cnt = 0, mem_req_last = 0;
  logic          seen_we = 1'b0;
  logic [AW-1:0] seen_addr = '0;
  logic [DW-1:0] seen_wdata = '0;
  logic [BW-1:0] seen_be = '0;
  bit            gnt_log[$];
  logic [DW-1:0] if_rx[$];
  logic [DW-1:0] d_rx[$];

  always @(negedge clk) begin : compare
    chk("if_gnt", if_gnt, e_if_gnt);
    chk("d_gnt", d_gnt, e_d_gnt);
    chk("if_rvalid", if_rvalid, e_if_rv);
    chk("d_rvalid", d_rvalid, e_d_rv);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
    chk("mem_req", mem_req, e_mem_req);
    chk("mem_we", mem_we, e_mem_we);
    chk("mem_addr", mem_addr, e_mem_addr);
    chk("mem_wdata", mem_wdata, e_mem_wdata);
    chk("mem_be", mem_be, e_mem_be);
`ifdef MEM_ARB_TIMEOUT_EN
    chk("bus_err", bus_err, e_err);
    if (bus_err) begin err_cnt++; err_cyc = cyc; end
`endif
    if (if_gnt)    begin if_gnt_cnt++; if_gnt_cyc = cyc; gnt_log.push_back(1'b0); end
    if (d_gnt)     begin d_gnt_cnt++;  d_gnt_cyc = cyc;  gnt_log.push_back(1'b1); end
    if (if_rvalid) begin if_rv_cnt++;  if_rv_cyc = cyc;  if_rx.push_back(if_rdata); end
    if (d_rvalid)  begin d_rv_cnt++;   d_rv_cyc = cyc;   d_rx.push_back(d_rdata); end
    if (mem_req) begin
      mem_req_cnt++; mem_req_last = cyc;
      seen_we = mem_we; seen_addr = mem_addr; seen_wdata = mem_wdata; seen_be = mem_be;
    end
  end

  // ---------------- helpers ----------------
  task automatic push_i(input logic [AW-1:0] a, input int life);
    req_t r;
    r.we = 1'b0; r.addr = a; r.wdata = '0; r.be = '1; r.life = life;
    iq.push_back(r);
  endtask

  task automatic push_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [BW-1:0] be, input int life);
    req_t r;
    r.we = we; r.addr = a; r.wdata = wd; r.be = be; r.life = life;
    dq.push_back(r);
  endtask

  task automatic set_mem(input int stall, input int lat, input bit noresp);
    cfg_stall = stall; stall_left = stall; cfg_lat = lat; cfg_noresp = noresp;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((iq.size() != 0 || dq.size() != 0 || m_valid) && n < budget);
    total++;
    if (iq.size() != 0 || dq.size() != 0 || m_valid) begin
      bad++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin : main
    int b_if_rv, b_d_rv, b_d_gnt, b_if_gnt, b_mreq, b_log, b_irx, b_drx, n;
    bit exp_order[4];
    logic [DW-1:0] exp_d[2];
    logic [DW-1:0] exp_i[2];

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_be", mem_be, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Fetch only
    set_mem(0, 1, 1'b0);
    b_d_rv = d_rv_cnt;
    @(posedge clk); #1;
    push_i(32'h0000_0004, 0);
    wait_idle("fetch_idle", 20);
    chk("fetch_gnt_lat", 64'(if_gnt_cyc - if_req_cyc), 1);
    chk("fetch_rvalid_lat", 64'(if_rv_cyc - if_req_cyc), 3);
    chk("fetch_rdata", if_rx[$], 32'h0000_0093);
    chk("fetch_mem_addr", seen_addr, 32'h4);
    chk("fetch_mem_we", seen_we, 0);
    chk("fetch_mem_be", seen_be, 4'hF);
    chk("fetch_no_d_rvalid", 64'(d_rv_cnt - b_d_rv), 0);

    // Store with two stall cycles
    set_mem(2, 1, 1'b0);
    b_d_rv = d_rv_cnt; b_d_gnt = d_gnt_cnt; b_mreq = mem_req_cnt;
    @(posedge clk); #1;
    push_d(1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011, 0);
    wait_idle("store_idle", 20);
    chk("store_mem_req_cycles", 64'(mem_req_cnt - b_mreq), 3);
    chk("store_gnt_once", 64'(d_gnt_cnt - b_d_gnt), 1);
    chk("store_no_rvalid", 64'(d_rv_cnt - b_d_rv), 0);
    chk("store_done_cycle", 64'(mem_req_last - d_gnt_cyc), 2);
    chk("store_wdata", seen_wdata, 32'hDEAD_BEEF);
    chk("store_be", seen_be, 4'b0011);
    chk("store_we", seen_we, 1);

    // Both requesters continuously after reset: D, I, D, I
    do_reset();
    set_mem(1, 2, 1'b0);
    b_log = gnt_log.size(); b_irx = if_rx.size(); b_drx = d_rx.size();
    @(posedge clk); #1;
    push_d(1'b0, 32'h200, '0, 4'hF, 0);
    push_d(1'b0, 32'h204, '0, 4'hF, 0);
    push_i(32'h10, 0);
    push_i(32'h14, 0);
    wait_idle("rr_idle", 60);
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_d = '{32'hFDFF_0200, 32'hFDFB_0204};
    exp_i = '{32'hFFEF_0010, 32'hFFEB_0014};
    chk("rr_gnt_count", 64'(gnt_log.size() - b_log), 4);
    for (int k = 0; k < 4; k++)
      if (b_log + k < gnt_log.size()) chk($sformatf("rr_order_%0d", k), gnt_log[b_log + k], exp_order[k]);
    chk("rr_d_rx_count", 64'(d_rx.size() - b_drx), 2);
    chk("rr_i_rx_count", 64'(if_rx.size() - b_irx), 2);
    for (int k = 0; k < 2; k++) begin
      if (b_drx + k < d_rx.size()) chk($sformatf("rr_d_data_%0d", k), d_rx[b_drx + k], exp_d[k]);
      if (b_irx + k < if_rx.size()) chk($sformatf("rr_i_data_%0d", k), if_rx[b_irx + k], exp_i[k]);
    end

    // Reset during WAIT, late memory response must be ignored
    set_mem(0, 6, 1'b0);
    b_d_rv = d_rv_cnt;
    @(posedge clk); #1;
    push_d(1'b0, 32'h300, '0, 4'hF, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(m_valid && m_acc) && n < 20);
    chk("rst_wait_reached", 64'(m_valid && m_acc), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_d_gnt", d_gnt, 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_mid_no_rvalid", 64'(d_rv_cnt - b_d_rv), 0);
    chk("rst_mid_d_rdata", d_rdata, 0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    set_mem(0, 1, 1'b0);
    b_if_rv = if_rv_cnt;
    @(posedge clk); #1;
    push_i(32'h0000_0004, 0);
    wait_idle("post_rst_idle", 20);
    chk("post_rst_fetch_rv", 64'(if_rv_cnt - b_if_rv), 1);
    chk("post_rst_fetch_data", if_rx[$], 32'h0000_0093);

    // Fetch gives up while a load is busy; it must never be granted
    set_mem(0, 4, 1'b0);
    b_if_gnt = if_gnt_cnt; b_d_rv = d_rv_cnt;
    @(posedge clk); #1;
    push_d(1'b0, 32'h500, '0, 4'hF, 0);
    push_i(32'h8, 2);
    wait_idle("drop_idle", 30);
    chk("drop_no_if_gnt", 64'(if_gnt_cnt - b_if_gnt), 0);
    chk("drop_d_rv", 64'(d_rv_cnt - b_d_rv), 1);
    chk("drop_d_data", d_rx[$], 32'hFAFF_0500);

`ifdef MEM_ARB_TIMEOUT_EN
    // Unanswered load times out
    set_mem(0, 1, 1'b1);
    b_d_rv = d_rv_cnt;
    b_if_rv = err_cnt;
    @(posedge clk); #1;
    push_d(1'b0, 32'h400, '0, 4'hF, 0);
    wait_idle("timeout_idle", 40);
    chk("timeout_d_rv", 64'(d_rv_cnt - b_d_rv), 1);
    chk("timeout_err_once", 64'(err_cnt - b_if_rv), 1);
    chk("timeout_d_rdata", d_rx[$], 0);
    chk("timeout_latency", 64'(d_rv_cyc - d_gnt_cyc), 17);
    chk("timeout_err_cycle", 64'(err_cyc - d_rv_cyc), 0);
    set_mem(0, 1, 1'b0);
    b_if_rv = if_rv_cnt;
    @(posedge clk); #1;
    push_i(32'h0000_0004, 0);
    wait_idle("after_timeout_idle", 20);
    chk("after_timeout_fetch", 64'(if_rv_cnt - b_if_rv), 1);
    chk("after_timeout_data", if_rx[$], 32'h0000_0093);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
